// File: rtl/alu_issue_if.sv
// ID-to-EX issue bundle: decoded ID operands, EX/MEM forwarding sources,
// pipeline control and the registered EX-stage issue back out.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic              alu_src;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic              mem_regwrite;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] store_data;
  logic              illegal;
  logic              load_use;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  in_valid, alu_op, funct, rs_addr, rt_addr, rs_data, rt_data, imm,
           alu_src, ex_regwrite, ex_memread, ex_rd, ex_result,
           mem_regwrite, mem_rd, mem_result, stall, flush,
    output ex_valid, alu_control, A, B, store_data, illegal, load_use,
           bubble_cnt
  );

  modport master (
    output in_valid, alu_op, funct, rs_addr, rt_addr, rs_data, rt_data, imm,
           alu_src, ex_regwrite, ex_memread, ex_rd, ex_result,
           mem_regwrite, mem_rd, mem_result, stall, flush,
    input  ex_valid, alu_control, A, B, store_data, illegal, load_use,
           bubble_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the ID instruction, forwards operands from EX/MEM,
// detects load-use hazards and registers the EX-stage ALU issue.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  // Returns {illegal, alu_control}.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] fn);
    logic [4:0] res;
    res = {1'b1, CTL_AND};
    case (op)
      2'b00: res = {1'b0, CTL_ADD};
      2'b01: res = {1'b0, CTL_SUB};
      2'b10: begin
        case (fn)
          6'b100000: res = {1'b0, CTL_ADD};
          6'b100010: res = {1'b0, CTL_SUB};
          6'b100100: res = {1'b0, CTL_AND};
          6'b100101: res = {1'b0, CTL_OR};
          6'b101010: res = {1'b0, CTL_SLT};
          default:   res = {1'b1, CTL_AND};
        endcase
      end
      default: res = {1'b1, CTL_AND};
    endcase
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // EX wins over MEM; a load in EX has no result yet, so it never forwards.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf,
    input logic              ex_wr,
    input logic              ex_rd_mem,
    input logic [4:0]        ex_dst,
    input logic [DATA_W-1:0] ex_val,
    input logic              mem_wr,
    input logic [4:0]        mem_dst,
    input logic [DATA_W-1:0] mem_val
  );
    if (ex_wr && !ex_rd_mem && (ex_dst != 5'd0) && (ex_dst == addr))
      return ex_val;
    else if (mem_wr && (mem_dst != 5'd0) && (mem_dst == addr))
      return mem_val;
    else
      return rf;
  endfunction

  logic [4:0]        w_dec;
  logic              w_dec_illegal;
  logic [3:0]        w_dec_ctl;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic [DATA_W-1:0] w_b_next;
  logic              w_load_use;
  logic              w_bubble;
  logic              w_ill_next;

  logic              r_vld_p1;
  logic [3:0]        r_ctl_p1;
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [DATA_W-1:0] r_sd_p1;
  logic              r_ill_p1;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_dec         = decode(bus.alu_op, bus.funct);
  assign w_dec_illegal = w_dec[4];
  assign w_dec_ctl     = w_dec[3:0];

  assign w_fwd_rs = fwd(bus.rs_addr, bus.rs_data, bus.ex_regwrite, bus.ex_memread,
                        bus.ex_rd, bus.ex_result, bus.mem_regwrite, bus.mem_rd,
                        bus.mem_result);
  assign w_fwd_rt = fwd(bus.rt_addr, bus.rt_data, bus.ex_regwrite, bus.ex_memread,
                        bus.ex_rd, bus.ex_result, bus.mem_regwrite, bus.mem_rd,
                        bus.mem_result);
  assign w_b_next = bus.alu_src ? bus.imm : w_fwd_rt;

  assign w_load_use = bus.in_valid && bus.ex_memread && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.rs_addr) || (bus.ex_rd == bus.rt_addr));
  assign w_bubble   = w_load_use || !bus.in_valid || w_dec_illegal;
  // Only a real instruction that survives the hazard check can be flagged.
  assign w_ill_next = bus.in_valid && !w_load_use && w_dec_illegal;

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_ctl_p1     <= 4'b0000;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_sd_p1      <= '0;
      r_ill_p1     <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (bus.flush) begin
      r_vld_p1     <= 1'b0;
      r_ctl_p1     <= 4'b0000;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_sd_p1      <= '0;
      r_ill_p1     <= 1'b0;
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else if (bus.stall) begin
      r_ill_p1     <= 1'b0;
    end else if (w_bubble) begin
      r_vld_p1     <= 1'b0;
      r_ctl_p1     <= 4'b0000;
      r_a_p1       <= '0;
      r_b_p1       <= '0;
      r_sd_p1      <= '0;
      r_ill_p1     <= w_ill_next;
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else begin
      r_vld_p1     <= 1'b1;
      r_ctl_p1     <= w_dec_ctl;
      r_a_p1       <= w_fwd_rs;
      r_b_p1       <= w_b_next;
      r_sd_p1      <= w_fwd_rt;
      r_ill_p1     <= 1'b0;
    end
  end

  assign bus.ex_valid    = r_vld_p1;
  assign bus.alu_control = r_ctl_p1;
  assign bus.A           = r_a_p1;
  assign bus.B           = r_b_p1;
  assign bus.store_data  = r_sd_p1;
  assign bus.illegal     = r_ill_p1;
  assign bus.load_use    = w_load_use;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a behavioural model.
module tb_alu_issue_stage;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EX-stage contents
  bit          m_vld;
  logic [3:0]  m_ctl;
  logic [31:0] m_a, m_b, m_sd;
  bit          m_ill;
  int          m_cnt;
  logic [3:0]  rtype_tbl [logic [5:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (bus.ex_regwrite && !bus.ex_memread && bus.ex_rd != 0 && bus.ex_rd == addr) return bus.ex_result;
    if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == addr) return bus.mem_result;
    return rf;
  endfunction

  function automatic bit ref_load_use();
    return bus.in_valid && bus.ex_memread && bus.ex_rd != 0 &&
           (bus.ex_rd == bus.rs_addr || bus.ex_rd == bus.rt_addr);
  endfunction

  task automatic model_reset();
    m_vld = 0; m_ctl = 0; m_a = 0; m_b = 0; m_sd = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic model_bubble(input bit ill);
    m_vld = 0; m_ctl = 0; m_a = 0; m_b = 0; m_sd = 0; m_ill = ill;
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic model_edge();
    bit         ok;
    logic [3:0] ctl;
    ok  = 1;
    ctl = 0;
    if (bus.alu_op == 2'b00) ctl = 4'b0010;
    else if (bus.alu_op == 2'b01) ctl = 4'b0110;
    else if (bus.alu_op == 2'b10 && rtype_tbl.exists(bus.funct)) ctl = rtype_tbl[bus.funct];
    else ok = 0;

    if (bus.flush) model_bubble(0);
    else if (bus.stall) m_ill = 0;
    else if (ref_load_use() || !bus.in_valid) model_bubble(0);
    else if (!ok) model_bubble(1);
    else begin
      m_vld = 1; m_ctl = ctl;
      m_a   = ref_fwd(bus.rs_addr, bus.rs_data);
      m_sd  = ref_fwd(bus.rt_addr, bus.rt_data);
      m_b   = bus.alu_src ? bus.imm : m_sd;
      m_ill = 0;
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid",    bus.ex_valid,    m_vld);
    chk("alu_control", bus.alu_control, m_ctl);
    chk("A",           bus.A,           m_a);
    chk("B",           bus.B,           m_b);
    chk("store_data",  bus.store_data,  m_sd);
    chk("illegal",     bus.illegal,     m_ill);
    chk("bubble_cnt",  bus.bubble_cnt,  m_cnt);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    chk("load_use", bus.load_use, ref_load_use());
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1; bus.alu_op = 0; bus.funct = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0; bus.alu_src = 0;
    bus.ex_regwrite = 0; bus.ex_memread = 0; bus.ex_rd = 0; bus.ex_result = 0;
    bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic randomize_inputs();
    logic [5:0] legal [5];
    legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.in_valid     = ($urandom % 8) != 0;
    bus.alu_op       = 2'($urandom);
    bus.funct        = (($urandom % 4) != 0) ? legal[$urandom % 5] : 6'($urandom);
    bus.rs_addr      = 5'($urandom % 4);
    bus.rt_addr      = 5'($urandom % 4);
    bus.rs_data      = $urandom;
    bus.rt_data      = $urandom;
    bus.imm          = $urandom;
    bus.alu_src      = 1'($urandom);
    bus.ex_regwrite  = 1'($urandom);
    bus.ex_memread   = ($urandom % 4) == 0;
    bus.ex_rd        = 5'($urandom % 4);
    bus.ex_result    = $urandom;
    bus.mem_regwrite = 1'($urandom);
    bus.mem_rd       = 5'($urandom % 4);
    bus.mem_result   = $urandom;
    bus.stall        = ($urandom % 10) == 0;
    bus.flush        = ($urandom % 12) == 0;
  endtask

  initial begin
    int prev_cnt;
    rtype_tbl[6'b100000] = 4'b0010;
    rtype_tbl[6'b100010] = 4'b0110;
    rtype_tbl[6'b100100] = 4'b0000;
    rtype_tbl[6'b100101] = 4'b0001;
    rtype_tbl[6'b101010] = 4'b0111;

    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // R-type sub, no hazards
    clear_inputs();
    bus.alu_op = 2'b10; bus.funct = 6'b100010;
    bus.rs_addr = 1; bus.rt_addr = 2; bus.rs_data = 9; bus.rt_data = 4;
    cycle();
    chk("sub_vld", bus.ex_valid, 1);
    chk("sub_ctl", bus.alu_control, 4'b0110);
    chk("sub_A", bus.A, 9);
    chk("sub_B", bus.B, 4);

    // EX over MEM forwarding, then MEM only, then r0 never forwarded
    clear_inputs();
    bus.rs_addr = 5; bus.rs_data = 32'h5; bus.alu_src = 1; bus.imm = 32'h10;
    bus.ex_regwrite = 1; bus.ex_rd = 5; bus.ex_result = 32'h77;
    bus.mem_regwrite = 1; bus.mem_rd = 5; bus.mem_result = 32'h11;
    cycle();
    chk("fwd_ex_A", bus.A, 32'h77);
    chk("fwd_imm_B", bus.B, 32'h10);
    bus.ex_regwrite = 0;
    cycle();
    chk("fwd_mem_A", bus.A, 32'h11);
    bus.ex_regwrite = 1; bus.rs_addr = 0; bus.ex_rd = 0; bus.mem_rd = 0;
    cycle();
    chk("fwd_r0_A", bus.A, 32'h5);

    // Stall holds a captured instruction
    bus.rs_data = 32'hABCD;
    cycle();
    bus.stall = 1; bus.rs_data = 32'h1234;
    cycle();
    chk("stall_hold_A", bus.A, 32'hABCD);
    bus.stall = 0;

    // Load-use hazard
    clear_inputs();
    bus.ex_memread = 1; bus.ex_rd = 3; bus.rt_addr = 3;
    prev_cnt = m_cnt;
    #1;
    chk("lu_comb", bus.load_use, 1);
    cycle();
    chk("lu_vld", bus.ex_valid, 0);
    chk("lu_cnt", bus.bubble_cnt, prev_cnt + 1);

    // Illegal funct: one-cycle pulse
    clear_inputs();
    bus.alu_op = 2'b10; bus.funct = 6'b000000;
    cycle();
    chk("ill_vld", bus.ex_valid, 0);
    chk("ill_pulse", bus.illegal, 1);
    clear_inputs();
    cycle();
    chk("ill_clear", bus.illegal, 0);

    // Flush with stall still loads a bubble
    prev_cnt = m_cnt;
    bus.flush = 1; bus.stall = 1;
    cycle();
    chk("flush_stall_vld", bus.ex_valid, 0);
    chk("flush_stall_cnt", bus.bubble_cnt, prev_cnt + 1);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end

    // Drive the counter into saturation
    clear_inputs();
    bus.in_valid = 0;
    for (int i = 0; i < 70000 && m_cnt < CNT_MAX; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("cnt_sat", bus.bubble_cnt, 16'hFFFF);

    // Asynchronous reset mid-cycle after a live capture
    clear_inputs();
    bus.rs_data = 32'hDEAD; bus.rt_data = 32'hBEEF;
    cycle();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("rst_cnt", bus.bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_vld", bus.ex_valid, 1);
    chk("post_rst_A", bus.A, 32'hDEAD);

    for (int i = 0; i < 500; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
